// File: rtl/phy_det_pkg.sv
// Shared constants and types for the packet-detection chain
// (magnitude stage, moving-sum feeder, accumulator).
package phy_det_pkg;

    localparam int DW_MAG      = 17;
    localparam int WIN_DEFAULT = 16;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } feeder_state_t;

    typedef logic [DW_MAG-1:0] sample_t;

endpackage

// File: rtl/delay_ram.sv
// Single-port read-first delay line storage: the old word at i_addr is
// returned on the same edge that overwrites it. Read data holds when idle.
module delay_ram #(
    parameter int DEPTH = 16,
    parameter int DW    = 17,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_rdata        <= r_mem[i_addr];
            r_mem[i_addr]  <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mov_sum_feeder.sv
// Moving-sum producer: emits each accepted sample together with the sample
// WIN positions earlier (zero while the window fills) and a one-cycle enable.
module mov_sum_feeder
    import phy_det_pkg::*;
#(
    parameter  int DW  = DW_MAG,
    parameter  int WIN = WIN_DEFAULT,
    localparam int AW  = $clog2(WIN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          flush,
    output logic          out_ena,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_a_d,
    output logic          win_full,
    output logic [AW:0]   fill_cnt
);

    localparam logic [AW:0]   FILL_MAX = (AW+1)'(WIN);
    localparam logic [AW:0]   FILL_PRE = (AW+1)'(WIN - 1);
    localparam logic [AW-1:0] WP_LAST  = AW'(WIN - 1);

    feeder_state_t r_state;
    logic [AW-1:0] r_wp;
    logic [AW:0]   r_fill;
    logic          r_ena;
    logic [DW-1:0] r_a;
    logic          r_ad_sel;
    logic          w_accept;
    logic          w_we;
    logic [DW-1:0] w_rdata;

    assign w_accept = in_valid & ~flush;
    assign w_we     = w_accept & ~rst;

    delay_ram #(
        .DEPTH (WIN),
        .DW    (DW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_wp),
        .i_wdata (in_data),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state  <= FILL;
            r_wp     <= '0;
            r_fill   <= '0;
            r_ena    <= 1'b0;
            r_a      <= '0;
            r_ad_sel <= 1'b0;
        end else begin
            r_ena <= w_accept;
            if (w_accept) begin
                r_a      <= in_data;
                // RAM output is uninitialised until a full window has been written
                r_ad_sel <= (r_state == RUN);
                r_wp     <= (r_wp == WP_LAST) ? '0 : r_wp + 1'b1;
                if (r_fill != FILL_MAX)
                    r_fill <= r_fill + 1'b1;
                if (r_state == FILL && r_fill == FILL_PRE)
                    r_state <= RUN;
            end
        end
    end

    assign out_ena  = r_ena;
    assign out_a    = r_a;
    assign out_a_d  = r_ad_sel ? w_rdata : '0;
    assign win_full = (r_state == RUN);
    assign fill_cnt = r_fill;

endmodule

// File: tb/tb_mov_sum_feeder.sv
// Directed bench for mov_sum_feeder at WIN=4, 16 and 2 with a reference
// accumulator per instance standing in for the downstream moving-sum block.
module tb_mov_sum_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [16:0] in_data = '0;

    always #5 clk = ~clk;

    logic        ena4, ena16, ena2;
    logic [16:0] a4, a16, a2, ad4, ad16, ad2;
    logic        full4, full16, full2;
    logic [2:0]  fill4;
    logic [4:0]  fill16;
    logic [1:0]  fill2;

    mov_sum_feeder #(.WIN(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
        .out_ena(ena4), .out_a(a4), .out_a_d(ad4), .win_full(full4), .fill_cnt(fill4));
    mov_sum_feeder #(.WIN(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
        .out_ena(ena16), .out_a(a16), .out_a_d(ad16), .win_full(full16), .fill_cnt(fill16));
    mov_sum_feeder #(.WIN(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
        .out_ena(ena2), .out_a(a2), .out_a_d(ad2), .win_full(full2), .fill_cnt(fill2));

    // Downstream accumulators, cleared by the same rst/flush as the feeder.
    logic [31:0] acc4 = '0, acc2 = '0;
    logic [31:0] sum4, sum2;
    assign sum4 = acc4 + (ena4 ? (32'(a4) - 32'(ad4)) : 32'd0);
    assign sum2 = acc2 + (ena2 ? (32'(a2) - 32'(ad2)) : 32'd0);

    always @(posedge clk) begin
        if (rst || flush) begin
            acc4 <= '0;
            acc2 <= '0;
        end else begin
            if (ena4) acc4 <= sum4;
            if (ena2) acc2 <= sum2;
        end
    end

    typedef struct {
        logic        rst;
        logic        flush;
        logic        vld;
        logic [16:0] data;
        logic        ena;
        logic [16:0] a;
        logic [16:0] ad;
        logic        full;
        int          fill;
        int          sum;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int errors = 0;

    task automatic push(input logic r, input logic f, input logic v, input int d,
                        input logic e, input int a, input int ad, input logic fu,
                        input int fi, input int s);
        vec_t x;
        x.rst = r; x.flush = f; x.vld = v; x.data = 17'(d);
        x.ena = e; x.a = 17'(a); x.ad = 17'(ad); x.full = fu; x.fill = fi; x.sum = s;
        vq.push_back(x);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the capturing edge.
    task automatic step(input logic r, input logic f, input logic v, input logic [16:0] d);
        @(negedge clk);
        rst = r; flush = f; in_valid = v; in_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // continuous 1..7 at WIN=4
        push(1,0,0,0,   0,0,0,0,0,0);
        push(0,0,1,1,   1,1,0,0,1,1);
        push(0,0,1,2,   1,2,0,0,2,3);
        push(0,0,1,3,   1,3,0,0,3,6);
        push(0,0,1,4,   1,4,0,1,4,10);
        push(0,0,1,5,   1,5,1,1,4,14);
        push(0,0,1,6,   1,6,2,1,4,18);
        push(0,0,1,7,   1,7,3,1,4,22);
        // gapped 10..50, three idle cycles after each
        push(1,0,0,0,   0,0,0,0,0,0);
        push(0,0,1,10,  1,10,0,0,1,10);
        for (int i = 0; i < 3; i++) push(0,0,0,0, 0,10,0,0,1,10);
        push(0,0,1,20,  1,20,0,0,2,30);
        for (int i = 0; i < 3; i++) push(0,0,0,0, 0,20,0,0,2,30);
        push(0,0,1,30,  1,30,0,0,3,60);
        for (int i = 0; i < 3; i++) push(0,0,0,0, 0,30,0,0,3,60);
        push(0,0,1,40,  1,40,0,1,4,100);
        for (int i = 0; i < 3; i++) push(0,0,0,0, 0,40,0,1,4,100);
        push(0,0,1,50,  1,50,10,1,4,140);
        push(0,0,0,0,   0,50,10,1,4,140);
        // flush colliding with a valid sample
        push(1,0,0,0,   0,0,0,0,0,0);
        push(0,0,1,100, 1,100,0,0,1,100);
        push(0,0,1,100, 1,100,0,0,2,200);
        push(0,0,1,100, 1,100,0,0,3,300);
        push(0,0,1,100, 1,100,0,1,4,400);
        push(0,0,1,100, 1,100,100,1,4,400);
        push(0,0,1,100, 1,100,100,1,4,400);
        push(0,1,1,999, 0,0,0,0,0,0);
        push(0,0,1,5,   1,5,0,0,1,5);
        push(0,0,1,6,   1,6,0,0,2,11);
        // reset mid-stream, 4th sample lost
        push(1,0,0,0,   0,0,0,0,0,0);
        push(0,0,1,7,   1,7,0,0,1,7);
        push(0,0,1,7,   1,7,0,0,2,14);
        push(0,0,1,7,   1,7,0,0,3,21);
        push(1,0,1,7,   0,0,0,0,0,0);
        push(0,0,1,7,   1,7,0,0,1,7);
        push(0,0,1,7,   1,7,0,0,2,14);
        push(0,0,1,7,   1,7,0,0,3,21);
        push(0,0,1,7,   1,7,0,1,4,28);
        push(0,0,1,7,   1,7,7,1,4,28);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].flush, vq[i].vld, vq[i].data);
            chk($sformatf("v%0d_ena", i),  int'(ena4),  int'(vq[i].ena));
            chk($sformatf("v%0d_a", i),    int'(a4),    int'(vq[i].a));
            chk($sformatf("v%0d_ad", i),   int'(ad4),   int'(vq[i].ad));
            chk($sformatf("v%0d_full", i), int'(full4), int'(vq[i].full));
            chk($sformatf("v%0d_fill", i), int'(fill4), vq[i].fill);
            chk($sformatf("v%0d_sum", i),  int'(sum4),  vq[i].sum);
        end

        // WIN=16: ramp 0..39, pointer wraps twice
        step(1, 0, 0, '0);
        chk("w16_rst_fill", int'(fill16), 0);
        chk("w16_rst_full", int'(full16), 0);
        for (int k = 0; k < 40; k++) begin
            step(0, 0, 1, 17'(k));
            chk($sformatf("w16_k%0d_ena", k),  int'(ena16),  1);
            chk($sformatf("w16_k%0d_a", k),    int'(a16),    k);
            chk($sformatf("w16_k%0d_ad", k),   int'(ad16),   (k >= 16) ? k - 16 : 0);
            chk($sformatf("w16_k%0d_fill", k), int'(fill16), (k >= 15) ? 16 : k + 1);
            chk($sformatf("w16_k%0d_full", k), int'(full16), (k >= 15) ? 1 : 0);
        end

        // WIN=2: full-scale alternating samples pass through unaltered
        step(1, 0, 0, '0);
        for (int i = 0; i < 8; i++) begin
            logic [16:0] d;
            d = (i % 2 == 0) ? 17'h1FFFF : 17'h00000;
            step(0, 0, 1, d);
            chk($sformatf("w2_i%0d_a", i),  int'(a2),  int'(d));
            chk($sformatf("w2_i%0d_ad", i), int'(ad2), (i >= 2) ? int'(d) : 0);
            chk($sformatf("w2_i%0d_sum", i), int'(sum2), 32'h1FFFF);
            chk($sformatf("w2_i%0d_bound", i), int'(sum2 <= 32'h3FFFE), 1);
        end
        chk("w2_full", int'(full2), 1);
        chk("w2_fill", int'(fill2), 2);

        step(0, 0, 0, '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
